// File: rtl/spi_byte_engine_if.sv
// spi_byte_engine_if: signal bundle between the SPI transaction controller
// (plus the device-side MISO pin) and the bit-level byte engine.
interface spi_byte_engine_if;
  logic       start;
  logic       clk_enable;
  logic [7:0] spi_tx_data;
  logic       miso;
  logic       sclk;
  logic       mosi;
  logic [7:0] spi_rx_data;
  logic       spi_byte_begin;
  logic       spi_byte_done;
  logic [2:0] bit_count;
  logic       state_machine_active;

  // Controller side; it also carries the MISO pin coming back from the device.
  modport master (
    output start, clk_enable, spi_tx_data, miso,
    input  sclk, mosi, spi_rx_data, spi_byte_begin, spi_byte_done,
           bit_count, state_machine_active
  );

  // Engine side.
  modport slave (
    input  start, clk_enable, spi_tx_data, miso,
    output sclk, mosi, spi_rx_data, spi_byte_begin, spi_byte_done,
           bit_count, state_machine_active
  );
endinterface

// File: rtl/spi_byte_engine.sv
// spi_byte_engine: SPI mode 0 (CPOL=0, CPHA=0), MSB-first single-byte shifter.
// SCLK half-period is CLK_DIV system clocks (1..255). Every output is a register.
// Optional build macro SPI_BYTE_ENGINE_LOOPBACK_EN: the receive path samples the
// engine's own MOSI instead of the MISO pin.
module spi_byte_engine #(
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  spi_byte_engine_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHIFT_LOW  = 2'd1,
    SHIFT_HIGH = 2'd2,
    DONE       = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     r_state;
  logic [7:0] r_div;
  logic [7:0] r_tx_sh;
  logic [7:0] r_rx_sh;
  logic       r_sclk;
  logic       r_mosi;
  logic [7:0] r_rx_data;
  logic       r_begin;
  logic       r_done;
  logic [2:0] r_bit_cnt;
  logic       r_active;

  logic       w_div_last;
  logic       w_abort;
  logic       w_sample;

  assign w_div_last = (r_div == DIV_LAST);
  assign w_abort    = ((r_state == SHIFT_LOW) || (r_state == SHIFT_HIGH)) && !bus.clk_enable;

`ifdef SPI_BYTE_ENGINE_LOOPBACK_EN
  // MOSI holds the current bit through the whole low phase, so it is valid at the rising edge.
  assign w_sample = r_mosi;
`else
  assign w_sample = bus.miso;
`endif

  assign bus.sclk                 = r_sclk;
  assign bus.mosi                 = r_mosi;
  assign bus.spi_rx_data          = r_rx_data;
  assign bus.spi_byte_begin       = r_begin;
  assign bus.spi_byte_done        = r_done;
  assign bus.bit_count            = r_bit_cnt;
  assign bus.state_machine_active = r_active;

  // Byte FSM: divider, SCLK generation, TX/RX shifting and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_div     <= 8'd0;
      r_tx_sh   <= 8'd0;
      r_rx_sh   <= 8'd0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_rx_data <= 8'd0;
      r_begin   <= 1'b0;
      r_done    <= 1'b0;
      r_bit_cnt <= 3'd0;
      r_active  <= 1'b0;
    end else begin
      r_begin <= 1'b0;
      r_done  <= 1'b0;
      if (w_abort) begin
        // Gate dropped mid-byte: park the bus, keep the last good receive byte.
        r_state   <= IDLE;
        r_div     <= 8'd0;
        r_sclk    <= 1'b0;
        r_mosi    <= 1'b0;
        r_bit_cnt <= 3'd0;
        r_active  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.start && bus.clk_enable) begin
              r_state   <= SHIFT_LOW;
              r_tx_sh   <= bus.spi_tx_data;
              r_mosi    <= bus.spi_tx_data[7];
              r_div     <= 8'd0;
              r_sclk    <= 1'b0;
              r_bit_cnt <= 3'd0;
              r_begin   <= 1'b1;
              r_active  <= 1'b1;
            end
          end
          SHIFT_LOW: begin
            if (w_div_last) begin
              // Rising SCLK edge: sample on the same clock.
              r_div   <= 8'd0;
              r_sclk  <= 1'b1;
              r_rx_sh <= {r_rx_sh[6:0], w_sample};
              r_state <= SHIFT_HIGH;
            end else begin
              r_div <= r_div + 8'd1;
            end
          end
          SHIFT_HIGH: begin
            if (w_div_last) begin
              // Falling SCLK edge: advance the bit and present the next one.
              r_div     <= 8'd0;
              r_sclk    <= 1'b0;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_tx_sh   <= {r_tx_sh[6:0], 1'b0};
              if (r_bit_cnt == 3'd7) begin
                r_state   <= DONE;
                r_mosi    <= 1'b0;
                r_done    <= 1'b1;
                r_rx_data <= r_rx_sh;
              end else begin
                r_state <= SHIFT_LOW;
                r_mosi  <= r_tx_sh[6];
              end
            end else begin
              r_div <= r_div + 8'd1;
            end
          end
          DONE: begin
            r_state  <= IDLE;
            r_active <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_byte_engine.sv
// tb_spi_byte_engine: randomized self-checking bench for spi_byte_engine.
// Expected waveforms are computed per cycle from the byte timing formulas.
module tb_spi_byte_engine;

  localparam int D = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [7:0] last_rx;

  spi_byte_engine_if bus();

  spi_byte_engine #(.CLK_DIV(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Received byte as seen by the model: loopback returns what was sent.
  function automatic logic [7:0] model_rx(input logic [7:0] tx, input logic [7:0] dev);
`ifdef SPI_BYTE_ENGINE_LOOPBACK_EN
    return tx;
`else
    return dev;
`endif
  endfunction

  // Expected {sclk, mosi, bit_count, begin, done, active} n cycles after the begin cycle.
  function automatic logic [7:0] exp_out(input int n, input logic [7:0] tx);
    int         bitidx;
    logic       s, m, b, dn;
    logic [2:0] bc;
    bitidx = n / (2 * D);
    if (n < 16 * D) begin
      s  = ((n / D) % 2) == 1;
      m  = tx[7 - bitidx];
      bc = 3'(bitidx);
      dn = 1'b0;
    end else begin
      s  = 1'b0;
      m  = 1'b0;
      bc = 3'd0;
      dn = 1'b1;
    end
    b = (n == 0);
    return {s, m, bc, b, dn, 1'b1};
  endfunction

  function automatic logic [15:0] observed();
    return {bus.sclk, bus.mosi, bus.bit_count, bus.spi_byte_begin,
            bus.spi_byte_done, bus.state_machine_active, bus.spi_rx_data};
  endfunction

  // One byte: lead = edges from call to the begin cycle; abort_at >= 0 drops clk_enable there.
  task automatic run_byte(input logic [7:0] tx, input logic [7:0] dev, input int lead,
                          input bit hold, input int abort_at, input string name);
    logic [15:0] got, exp;
    logic [7:0]  erx;
    erx = model_rx(tx, dev);
    bus.spi_tx_data = tx;
    bus.start       = 1'b1;
    bus.clk_enable  = 1'b1;
    for (int i = 0; i < lead; i++) begin
      @(posedge clk); #1;
      if (i != lead - 1) begin
        got = observed();
        exp = {8'h00, last_rx};
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL %s_gap got=%h exp=%h", name, got, exp);
        end
      end
    end
    for (int n = 0; n <= 16 * D; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      got = observed();
      exp = {exp_out(n, tx), (n < 16 * D) ? last_rx : erx};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s n=%0d got=%h exp=%h", name, n, got, exp);
      end
      if (n == 0 && !hold) bus.start = 1'b0;
      if (n == 1) bus.spi_tx_data = 8'($urandom);
      if (n < 16 * D) bus.miso = dev[7 - n / (2 * D)];
      else            bus.miso = 1'($urandom);
      if (n == abort_at) begin
        bus.clk_enable = 1'b0;
        bus.start      = 1'b0;
        @(posedge clk); #1;
        got = observed();
        exp = {8'h00, last_rx};
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL %s_abort got=%h exp=%h", name, got, exp);
        end
        for (int k = 0; k < 20; k++) begin
          @(posedge clk); #1;
          got = observed();
          checks++;
          if (got !== exp) begin
            failures++;
            $display("FAIL %s_after_abort k=%0d got=%h exp=%h", name, k, got, exp);
          end
        end
        bus.clk_enable = 1'b1;
        return;
      end
    end
    last_rx = erx;
    if (!hold) begin
      @(posedge clk); #1;
      got = observed();
      exp = {8'h00, last_rx};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s_tail got=%h exp=%h", name, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    logic [15:0] got;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = observed();
    checks++;
    if (got !== 16'h0000) begin
      failures++;
      $display("FAIL reset_init got=%h exp=0000", got);
    end
    rst = 1'b0;
    // Launch a byte, then reset it in the middle.
    bus.spi_tx_data = 8'hC3;
    bus.start       = 1'b1;
    bus.clk_enable  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3 * D + 2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      got = observed();
      checks++;
      if (got !== 16'h0000) begin
        failures++;
        $display("FAIL reset_mid i=%0d got=%h exp=0000", i, got);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      got = observed();
      checks++;
      if (got !== 16'h0000) begin
        failures++;
        $display("FAIL reset_after i=%0d got=%h exp=0000", i, got);
      end
    end
    last_rx = 8'h00;
  endtask

  task automatic test_basic();
    run_byte(8'h0B, 8'hA5, 1, 1'b0, -1, "basic");
  endtask

  task automatic test_back_to_back();
    run_byte(8'h0B, 8'h5A, 1, 1'b1, -1, "b2b_first");
    run_byte(8'h14, 8'hC6, 2, 1'b0, -1, "b2b_second");
  endtask

  task automatic test_abort();
    run_byte(8'h96, 8'h3E, 1, 1'b0, -1, "pre_abort");
    run_byte(8'hE7, 8'h81, 1, 1'b0, 6 * D, "abort_fall3");
    run_byte(8'($urandom), 8'($urandom), 1, 1'b0, int'($urandom_range(1, 16 * D - 1)), "abort_rand");
    run_byte(8'h71, 8'h2D, 1, 1'b0, -1, "post_abort");
  endtask

  task automatic test_no_enable();
    logic [15:0] got;
    bus.start      = 1'b1;
    bus.clk_enable = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      got = observed();
      checks++;
      if (got !== {8'h00, last_rx}) begin
        failures++;
        $display("FAIL no_enable i=%0d got=%h exp=%h", i, got, {8'h00, last_rx});
      end
    end
    bus.start      = 1'b0;
    bus.clk_enable = 1'b1;
  endtask

  task automatic test_zero_miso();
    run_byte(8'h3C, 8'h00, 1, 1'b0, -1, "zero_miso");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_byte(8'($urandom), 8'($urandom), 1, 1'b0, -1, "random");
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    last_rx         = 8'h00;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.clk_enable  = 1'b0;
    bus.spi_tx_data = 8'h00;
    bus.miso        = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_no_enable();
    test_zero_miso();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_byte_engine.md
# spi_byte_engine

Bit-level SPI master shifter for the PmodACL2 accelerometer path. It sits directly below the SPI transaction controller, which supplies `start`, `spi_tx_data` and `clk_enable`. The engine shifts one byte at a time in SPI mode 0 (CPOL=0, CPHA=0), MSB first. It returns to the controller the received byte, byte begin/done pulses, the running `bit_count` and an activity flag. Chip select is not handled here; the controller owns `ncs_o`.

## Interface
- `CLK_DIV`, default 4: system clocks per SCLK half-period; legal range 1..255.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: byte request, sampled only in IDLE.
- `clk_enable` input 1: SCLK gate; must be high to launch a byte; low aborts a byte in flight.
- `spi_tx_data` input 8: byte to transmit, latched on launch.
- `miso` input 1: serial data from the device.
- `sclk` output 1: SPI clock; idles low.
- `mosi` output 1: serial data to the device.
- `spi_rx_data` output 8: last fully received byte.
- `spi_byte_begin` output 1: one-cycle pulse on launch.
- `spi_byte_done` output 1: one-cycle pulse on byte completion.
- `bit_count` output 3: number of falling SCLK edges so far in the current byte, mod 8.
- `state_machine_active` output 1: high in every state except IDLE.

## Operation
- Reset values: all outputs 0; state IDLE; divider 0; shift registers 0.
- States:
  - IDLE: if `start & clk_enable`, latch `spi_tx_data`, then go to SHIFT_LOW.
  - SHIFT_LOW: after CLK_DIV cycles, go to SHIFT_HIGH.
  - SHIFT_HIGH: after CLK_DIV cycles, go to SHIFT_LOW, or to DONE after the 8th falling edge.
  - DONE: one cycle, then IDLE.
- Launch: `spi_byte_begin` = 1 in the first SHIFT_LOW cycle. In the same cycle `mosi` = tx[7], `bit_count` = 0 and `sclk` = 0.
- Rising SCLK edge (SHIFT_LOW→SHIFT_HIGH): `sclk` goes to 1; `miso` is sampled into the receive shift register on that same clock, shifting left (MSB first).
- Falling SCLK edge (SHIFT_HIGH→SHIFT_LOW/DONE): `sclk` goes to 0; `bit_count` increments; `mosi` presents the next tx bit. On the 8th falling edge `bit_count` wraps 7→0.
- DONE: `spi_rx_data` loads the receive shift register; `spi_byte_done` = 1; `mosi` = 0.
- `start` is ignored outside IDLE; a held `start` relaunches on the first IDLE cycle after DONE.
- Abort: if `clk_enable` is low in any SHIFT state, the next cycle is IDLE with:
  - `sclk` = 0, `mosi` = 0, `bit_count` = 0;
  - no done pulse;
  - `spi_rx_data` unchanged.
- `start` with `clk_enable` low in IDLE: no launch, outputs unchanged.
- `rst` mid-byte: all outputs take their reset values on the next edge; no done pulse.
- `spi_tx_data` changes after launch have no effect on the byte in flight.

## Timing
- Launch decision at cycle T; everything below is relative to T.
- `spi_byte_begin` and `state_machine_active` go high at T+1.
- Rising SCLK edge k (k=0..7) occurs at T+1+(2k+1)·CLK_DIV.
- Falling SCLK edge k occurs at T+1+(2k+2)·CLK_DIV; `bit_count` = 1 first at T+1+2·CLK_DIV.
- `spi_byte_done` and new `spi_rx_data` appear at T+1+16·CLK_DIV.
- `state_machine_active` falls at T+2+16·CLK_DIV.
- Earliest next launch decision: T+2+16·CLK_DIV, giving a next `spi_byte_begin` at T+3+16·CLK_DIV.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- `SPI_BYTE_ENGINE_LOOPBACK_EN` defined: the receive path samples the engine's own `mosi` instead of `miso`, so `spi_rx_data` equals the transmitted byte after each completed byte. The `miso` pin is ignored.
- Not defined: normal operation; `miso` is sampled as described above.

## Test plan
- Reset: assert `rst` 3 cycles during an active byte → all outputs 0, state IDLE, no `spi_byte_done`.
- CLK_DIV=4, `spi_tx_data`=0x0B, device returns 0xA5 on `miso` (changing after each falling edge) → `mosi` bits 0,0,0,0,1,0,1,1; 8 SCLK pulses each 4 cycles high; `spi_byte_done` at T+65; `spi_rx_data`=0xA5.
- `start` held high, bytes 0x0B then 0x14 → two complete bytes; second `spi_byte_begin` exactly 2 cycles after the first `spi_byte_done`; `bit_count` sequence 0..7,0 for each byte.
- `clk_enable` dropped after the 3rd falling edge → `sclk` low next cycle, IDLE, `bit_count`=0, no done pulse, previous `spi_rx_data` retained.
- `start`=1 with `clk_enable`=0 for 100 cycles → `sclk` stays 0, no begin pulse, `state_machine_active`=0.
- With `SPI_BYTE_ENGINE_LOOPBACK_EN` defined, transmit 0x3C with `miso` tied 0 → `spi_rx_data`=0x3C.
